// File: rtl/vault_pkg.sv
// Shared definitions for the password vault RAM: entry field layout, default widths
// and the lookup FSM state encoding.
package vault_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned KEY_W_DEF  = 128;

  // 256-bit entry: account in the upper half, encrypted password in the lower half
  localparam int unsigned ACC_HI = 255;
  localparam int unsigned ACC_LO = 128;
  localparam int unsigned PW_HI  = 127;
  localparam int unsigned PW_LO  = 0;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StCmp,
    StDone
  } lookup_state_e;

endpackage

// File: rtl/vault_lookup.sv
// Read-side lookup engine: linearly scans the vault RAM for an account name and returns
// the first matching entry's index and encrypted password.
module vault_lookup
  import vault_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned KEY_W  = KEY_W_DEF,
  parameter int unsigned DATA_W = 2 * KEY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [KEY_W-1:0]  account,
  input  logic [ADDR_W-1:0] max_address,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] match_index,
  output logic [KEY_W-1:0]  password_enc
);

  lookup_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [KEY_W-1:0]  acc_q, acc_d;
  logic [ADDR_W-1:0] max_q, max_d;
  logic              found_q, found_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [KEY_W-1:0]  pw_q, pw_d;

  logic              acc_hit;
  logic              last_addr;

  assign acc_hit   = (mem_q[ACC_HI:ACC_LO] == acc_q);
  // max_q is non-zero whenever a scan is running, so max_q - 1 cannot underflow here
  assign last_addr = (addr_q == (max_q - ADDR_W'(1)));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    max_d   = max_q;
    found_d = found_q;
    idx_d   = idx_q;
    pw_d    = pw_q;

    case (state_q)
      StIdle: begin
        if (go) begin
          acc_d   = account;
          max_d   = max_address;
          found_d = 1'b0;
          idx_d   = '0;
          pw_d    = '0;
          addr_d  = '0;
          state_d = (max_address == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        state_d = StCmp;
      end
      StCmp: begin
        if (acc_hit) begin
          found_d = 1'b1;
          idx_d   = addr_q;
          pw_d    = mem_q[PW_HI:PW_LO];
          state_d = StDone;
        end else if (last_addr) begin
          state_d = StDone;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = StRead;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      acc_q   <= '0;
      max_q   <= '0;
      found_q <= 1'b0;
      idx_q   <= '0;
      pw_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      max_q   <= max_d;
      found_q <= found_d;
      idx_q   <= idx_d;
      pw_q    <= pw_d;
    end
  end

  assign mem_addr     = addr_q;
  assign busy         = (state_q == StRead) || (state_q == StCmp);
  assign done         = (state_q == StDone);
  assign found        = found_q;
  assign match_index  = idx_q;
  assign password_enc = pw_q;

endmodule
